booth_dispatcher: RTL and testbench

Upstream feeder for the sequential Booth multiplier. Buffers operand pairs in a small FIFO with a valid/ready input, issues them to the multiplier one at a time (operands plus a one-cycle `start` pulse), waits for `done`, and registers each product with its tag into a valid/ready output slot. A per-operation watchdog converts a missing `done` into an error result, so a stalled multiplier cannot hang the pipeline.

---
 rtl/booth_pkg.sv | 15 +
 rtl/booth_operand_fifo.sv | 69 ++++++
 rtl/booth_dispatcher.sv | 179 +++++++++++++++++
 tb/tb_booth_dispatcher.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and default sizing for the Booth multiplier dispatcher.
package booth_pkg;

    localparam int BOOTH_W       = 8;
    localparam int BOOTH_DEPTH   = 4;
    localparam int BOOTH_TIMEOUT = 64;
    localparam int BOOTH_TAGW    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } disp_state_t;

endpackage

// File: rtl/booth_operand_fifo.sv
// Operand-pair FIFO: stores {a, b, tag} entries, exposes the head combinationally.
// Pushes while full and pops while empty are dropped internally.
module booth_operand_fifo #(
    parameter int W     = 8,
    parameter int TAGW  = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_a,
    input  logic [W-1:0]             push_b,
    input  logic [TAGW-1:0]          push_tag,
    input  logic                     pop,
    output logic [W-1:0]             head_a,
    output logic [W-1:0]             head_b,
    output logic [TAGW-1:0]          head_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = 2 * W + TAGW;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    assign {head_a, head_b, head_tag} = mem[rd_ptr];

    // Entry storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {push_a, push_b, push_tag};
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/booth_dispatcher.sv
// Feeds queued operand pairs to a sequential multiplier one at a time and
// returns each product with its tag through a valid/ready result slot.
// A watchdog turns a missing done into an error result.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a queued pair and a free result slot
// ISSUE | mul_start high for one cycle, watchdog cleared
// WAIT  | operands held; first cycle ignores done (stale level), then
//       | done captures the product, or watchdog expiry reports error
module booth_dispatcher
    import booth_pkg::*;
#(
    parameter int W       = BOOTH_W,
    parameter int DEPTH   = BOOTH_DEPTH,
    parameter int TIMEOUT = BOOTH_TIMEOUT,
    parameter int TAGW    = BOOTH_TAGW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic [TAGW-1:0]   in_tag,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    output logic              mul_start,
    input  logic              mul_done,
    input  logic [2*W-1:0]    mul_m,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    out_m,
    output logic [TAGW-1:0]   out_tag,
    output logic              out_err,
    output logic              busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // Last WAIT cycle: the counter would reach TIMEOUT on this edge.
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    disp_state_t state;
    disp_state_t state_nxt;

    logic [W-1:0]           head_a;
    logic [W-1:0]           head_b;
    logic [TAGW-1:0]        head_tag;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;

    logic                   push;
    logic                   pop;
    logic                   slot_free;
    logic                   done_ok;
    logic                   timed_out;
    logic [CW-1:0]          wdog;
    logic [TAGW-1:0]        tag_q;

    assign push      = in_valid && in_ready;
    assign in_ready  = !fifo_full;
    assign slot_free = !out_valid || out_ready;
    assign busy      = (state != IDLE) || (fifo_count != '0);

    booth_operand_fifo #(
        .W     (W),
        .TAGW  (TAGW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_a   (in_a),
        .push_b   (in_b),
        .push_tag (in_tag),
        .pop      (pop),
        .head_a   (head_a),
        .head_b   (head_b),
        .head_tag (head_tag),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_ok || timed_out) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Per-state outputs and strobes; done beats the watchdog in the same cycle.
    always_comb begin
        mul_start = 1'b0;
        pop       = 1'b0;
        done_ok   = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                pop = !fifo_empty && slot_free;
            end
            ISSUE: begin
                mul_start = 1'b1;
            end
            WAIT: begin
                done_ok   = mul_done && (wdog != '0);
                timed_out = !done_ok && (wdog == WD_LAST);
            end
            default: begin
                mul_start = 1'b0;
            end
        endcase
    end

    // Operand/tag registers load on pop; watchdog clears in ISSUE, counts in WAIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mul_a <= '0;
            mul_b <= '0;
            tag_q <= '0;
            wdog  <= '0;
        end else begin
            if (pop) begin
                mul_a <= head_a;
                mul_b <= head_b;
                tag_q <= head_tag;
            end
            if (state == ISSUE) begin
                wdog <= '0;
            end else if (state == WAIT) begin
                wdog <= wdog + CW'(1);
            end
        end
    end

    // Result slot: loads on completion, drains on handshake, otherwise holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_m     <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (done_ok || timed_out) begin
            out_valid <= 1'b1;
            out_m     <= done_ok ? mul_m : '0;
            out_tag   <= tag_q;
            out_err   <= !done_ok;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_dispatcher.sv
module tb_booth_dispatcher;

    localparam int W       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int TAGW    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a;
    logic [W-1:0]      in_b;
    logic [TAGW-1:0]   in_tag;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_start;
    logic              mul_done = 1'b0;
    logic [2*W-1:0]    mul_m = '0;
    logic              out_valid;
    logic              out_ready;
    logic [2*W-1:0]    out_m;
    logic [TAGW-1:0]   out_tag;
    logic              out_err;
    logic              busy;

    typedef struct {
        logic [15:0] m;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    bit   hang_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int starts   = 0;
    int last_start_cyc = 0;

    bit level_mode = 0;
    int lat_min    = 3;
    int lat_max    = 6;
    bit rnd_ready  = 0;

    booth_dispatcher #(
        .W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TAGW(TAGW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_start (mul_start),
        .mul_done  (mul_done),
        .mul_m     (mul_m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_m     (out_m),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Random consumer back-pressure when enabled.
    always @(posedge clk) begin
        #2;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Multiplier model: reacts to mul_start, returns a*b after a random latency.
    // In level mode done (and the old product) stay up through the first WAIT cycle.
    logic [7:0] cap_a = '0, cap_b = '0;
    bit act = 0, cur_hang = 0, stab_on = 0, prev_start = 0;
    int k = 0, lat = 0;

    always @(negedge clk) begin
        if (mul_start === 1'b1) begin
            checks++;
            if (prev_start) begin
                failures++;
                $display("FAIL start_pulse: mul_start high two cycles running, required one cycle");
            end
            checks++;
            if (hang_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_start: a=%0d b=%0d, required no start", mul_a, mul_b);
                cur_hang = 0;
            end else begin
                cur_hang = hang_q.pop_front();
            end
            cap_a = mul_a;
            cap_b = mul_b;
            k = 0;
            act = 1;
            stab_on = 1;
            lat = $urandom_range(lat_min, lat_max);
            starts++;
            last_start_cyc = cyc;
        end else if (act) begin
            k++;
            if (!reset) stab_on = 0;
            if (stab_on) begin
                checks++;
                if (mul_a !== cap_a || mul_b !== cap_b) begin
                    failures++;
                    $display("FAIL operand_hold: a=%0d b=%0d, required a=%0d b=%0d",
                             mul_a, mul_b, cap_a, cap_b);
                end
            end
            if (k == 2 && level_mode) mul_done = 1'b0;
            if (k == lat && !cur_hang) begin
                mul_m    = {8'd0, cap_a} * {8'd0, cap_b};
                mul_done = 1'b1;
                act      = 0;
            end
        end else if (!level_mode && mul_done) begin
            mul_done = 1'b0;
        end
        prev_start = (mul_start === 1'b1);
    end

    // Result monitor and hold-stability checker.
    exp_t       mon_e;
    bit         held = 0;
    logic [15:0] h_m;
    logic [3:0]  h_tag;
    logic        h_err;

    always @(negedge clk) begin
        if (reset && held && out_valid) begin
            checks++;
            if (out_m !== h_m || out_tag !== h_tag || out_err !== h_err) begin
                failures++;
                $display("FAIL result_hold: m=%0d tag=%0d err=%0d, required m=%0d tag=%0d err=%0d",
                         out_m, out_tag, out_err, h_m, h_tag, h_err);
            end
        end
        if (reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL result_unexpected: m=%0d tag=%0d err=%0d, required no result",
                         out_m, out_tag, out_err);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_m !== mon_e.m || out_tag !== mon_e.tag || out_err !== mon_e.err) begin
                    failures++;
                    $display("FAIL result: m=%0d tag=%0d err=%0d, required m=%0d tag=%0d err=%0d",
                             out_m, out_tag, out_err, mon_e.m, mon_e.tag, mon_e.err);
                end
                if (mon_e.err) begin
                    checks++;
                    if (cyc - last_start_cyc > TIMEOUT + 1 || cyc - last_start_cyc < TIMEOUT) begin
                        failures++;
                        $display("FAIL timeout_latency: %0d cycles after start, required %0d..%0d",
                                 cyc - last_start_cyc, TIMEOUT, TIMEOUT + 1);
                    end
                end
            end
        end
        held  = reset && out_valid && !out_ready;
        h_m   = out_m;
        h_tag = out_tag;
        h_err = out_err;
    end

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] req_v);
        checks++;
        if (act_v !== req_v) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act_v, req_v);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t, input bit hang);
        int   waitc = 0;
        exp_t e;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        while (!in_ready && waitc < 500) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: in_ready=0 for %0d cycles, required 1", waitc);
            in_valid = 1'b0;
            return;
        end
        e.m   = hang ? 16'd0 : ({8'd0, a} * {8'd0, b});
        e.tag = t;
        e.err = hang;
        exp_q.push_back(e);
        hang_q.push_back(hang);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rnd_ready = 0;
        out_ready = 1'b1;
        while (!(exp_q.size() == 0 && !out_valid && !busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid || busy) begin
            failures++;
            $display("FAIL drain: %0d results outstanding after %0d cycles, required 0", exp_q.size(), n);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  1);
        chk({tag, "_mul_start"}, 32'(mul_start), 0);
        chk({tag, "_mul_a"},     32'(mul_a),     0);
        chk({tag, "_mul_b"},     32'(mul_b),     0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_m"},     32'(out_m),     0);
        chk({tag, "_out_tag"},   32'(out_tag),   0);
        chk({tag, "_out_err"},   32'(out_err),   0);
        chk({tag, "_busy"},      32'(busy),      0);
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "global timeout");
    end

    initial begin
        int s0;
        bit seen;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // Single op with exact issue timing.
        s0 = starts;
        push(8'd7, 8'd3, 4'd1, 0);
        chk("single_start_cycle0", 32'(mul_start), 0);
        @(posedge clk); #1;
        chk("single_start_cycle1", 32'(mul_start), 1);
        chk("single_mul_a", 32'(mul_a), 7);
        chk("single_mul_b", 32'(mul_b), 3);
        drain();
        chk("single_starts", 32'(starts - s0), 1);

        // Two-op stream.
        s0 = starts;
        push(8'd12, 8'd5, 4'd2, 0);
        push(8'd25, 8'd10, 4'd3, 0);
        drain();
        chk("stream_starts", 32'(starts - s0), 2);

        // Backpressure: one in flight plus four queued fills everything.
        s0 = starts;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(8 + i), 0);
        end
        chk("bp_in_ready_full", 32'(in_ready), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_in_ready_held", 32'(in_ready), 0);
        chk("bp_single_issue", 32'(starts - s0), 1);
        chk("bp_out_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        push(8'd200, 8'd201, 4'd13, 0);
        drain();
        chk("bp_starts", 32'(starts - s0), 6);

        // Random stream with random consumer readiness.
        s0 = starts;
        rnd_ready = 1;
        for (int i = 0; i < 30; i++) begin
            push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        chk("random_starts", 32'(starts - s0), 30);

        // Stale done: multiplier holds done and its old product into the next op.
        level_mode = 1;
        for (int i = 0; i < 8; i++) begin
            push(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 4'(i), 0);
        end
        drain();
        level_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        // Timeout, then a normal op.
        s0 = starts;
        push(8'd3, 8'd4, 4'd5, 1);
        push(8'd9, 8'd9, 4'd6, 0);
        drain();
        chk("timeout_starts", 32'(starts - s0), 2);

        // Reset during WAIT with two pairs queued.
        lat_min = 20;
        lat_max = 20;
        push(8'd11, 8'd13, 4'd7, 0);
        push(8'd2, 8'd2, 4'd8, 0);
        push(8'd4, 8'd4, 4'd9, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        hang_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        chk_reset_values("midwait");
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("late_done_ignored", 32'(seen), 0);

        // Recovery op.
        lat_min = 3;
        lat_max = 6;
        push(8'd5, 8'd6, 4'd10, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
